// File: rtl/button_mode_controller.sv
// Button front end: per-channel 2-flop synchroniser, debounce and press/short/
// long/repeat event generation, plus the display-mode register driven by the
// mode button's events or a direct load.
module button_mode_controller #(
  parameter int NUM_BTN       = 3,
  parameter int DEB_CYCLES    = 50000,
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int NUM_MODES     = 5,
  parameter int MODE_W        = 3,
  parameter int MODE_BTN      = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_BTN-1:0] BTN_N,
  input  logic               MODE_LOCK,
  input  logic               MODE_LOAD,
  input  logic [MODE_W-1:0]  MODE_LOAD_VAL,
  output logic [NUM_BTN-1:0] HELD,
  output logic [NUM_BTN-1:0] PRESS,
  output logic [NUM_BTN-1:0] SHORT,
  output logic [NUM_BTN-1:0] LONG,
  output logic [NUM_BTN-1:0] REPEAT,
  output logic [MODE_W-1:0]  MODE,
  output logic               MODE_CHANGE
);

  localparam int HC_SPAN = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HC_W    = $clog2(HC_SPAN);
  localparam int CNT_W   = $clog2(DEB_CYCLES);

  localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [HC_W-1:0]   LONG_LAST  = HC_W'(LONG_CYCLES - 1);
  localparam logic [HC_W-1:0]   RPT_LAST   = HC_W'(REPEAT_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W:0]   MODE_COUNT = (MODE_W + 1)'(NUM_MODES);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RPT} state_t;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             s;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic             held_q, held_d;
    state_t           state_q, state_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic             press_q, press_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;

    // Next state: synchroniser shift, debounce counter, and the event FSM.
    // The FSM looks at held_d so PRESS/SHORT land on the same edge as HELD.
    always_comb begin
      sync1_d = BTN_N[i];
      sync2_d = sync1_q;
      s       = ~sync2_q;

      held_d = held_q;
      deb_d  = '0;
      if (s != held_q) begin
        if (deb_q == DEB_LAST) begin
          held_d = ~held_q;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end

      state_d = state_q;
      hc_d    = hc_q;
      press_d = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      rpt_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (held_d && !held_q) begin
            press_d = 1'b1;
            hc_d    = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // A release on the terminal-count cycle beats the LONG event.
          if (!held_d) begin
            short_d = 1'b1;
            hc_d    = '0;
            state_d = ST_IDLE;
          end else if (hc_q == LONG_LAST) begin
            long_d  = 1'b1;
            hc_d    = '0;
            state_d = ST_RPT;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        ST_RPT: begin
          if (!held_d) begin
            hc_d    = '0;
            state_d = ST_IDLE;
          end else if (hc_q == RPT_LAST) begin
            rpt_d = 1'b1;
            hc_d  = '0;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
        default: begin
          hc_d    = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    // Channel state registers; sync flops reset to the released level.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        deb_q   <= '0;
        held_q  <= 1'b0;
        state_q <= ST_IDLE;
        hc_q    <= '0;
        press_q <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        deb_q   <= deb_d;
        held_q  <= held_d;
        state_q <= state_d;
        hc_q    <= hc_d;
        press_q <= press_d;
        short_q <= short_d;
        long_q  <= long_d;
        rpt_q   <= rpt_d;
      end
    end

    assign HELD[i]   = held_q;
    assign PRESS[i]  = press_q;
    assign SHORT[i]  = short_q;
    assign LONG[i]   = long_q;
    assign REPEAT[i] = rpt_q;
  end

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mode_change_q, mode_change_d;

  // Mode next value: a valid load wins, otherwise the mode button's registered
  // events step forward (SHORT) or backward (LONG/REPEAT) unless locked.
  always_comb begin
    mode_d = mode_q;
    if (MODE_LOAD) begin
      if ({1'b0, MODE_LOAD_VAL} < MODE_COUNT) begin
        mode_d = MODE_LOAD_VAL;
      end
    end else if (!MODE_LOCK) begin
      if (SHORT[MODE_BTN]) begin
        mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
      end else if (LONG[MODE_BTN] || REPEAT[MODE_BTN]) begin
        mode_d = (mode_q == '0) ? MODE_LAST : mode_q - 1'b1;
      end
    end
    mode_change_d = (mode_d != mode_q);
  end

  // Mode register and its change strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q        <= '0;
      mode_change_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
    end
  end

  assign MODE        = mode_q;
  assign MODE_CHANGE = mode_change_q;

endmodule

// File: tb/tb_button_mode_controller.sv
// Directed bench for button_mode_controller with short debounce/hold timings.
module tb_button_mode_controller;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] BTN_N;
  logic       MODE_LOCK;
  logic       MODE_LOAD;
  logic [2:0] MODE_LOAD_VAL;
  logic [2:0] HELD, PRESS, SHORT, LONG, REPEAT;
  logic [2:0] MODE;
  logic       MODE_CHANGE;

  int n_cmp = 0;
  int n_bad = 0;

  button_mode_controller #(
    .NUM_BTN(3), .DEB_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3),
    .NUM_MODES(5), .MODE_W(3), .MODE_BTN(2)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_N(BTN_N), .MODE_LOCK(MODE_LOCK),
    .MODE_LOAD(MODE_LOAD), .MODE_LOAD_VAL(MODE_LOAD_VAL), .HELD(HELD),
    .PRESS(PRESS), .SHORT(SHORT), .LONG(LONG), .REPEAT(REPEAT),
    .MODE(MODE), .MODE_CHANGE(MODE_CHANGE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; BTN_N = 3'b111; MODE_LOCK = 1'b0; MODE_LOAD = 1'b0; MODE_LOAD_VAL = 3'd0;
    repeat (3) tick();
    n_cmp++; if (HELD !== 3'b000) begin n_bad++; $display("FAIL reset_held got %b want 000", HELD); end
    n_cmp++; if ({PRESS, SHORT, LONG, REPEAT} !== 12'h000) begin n_bad++; $display("FAIL reset_events got %h want 000", {PRESS, SHORT, LONG, REPEAT}); end
    n_cmp++; if (MODE !== 3'd0 || MODE_CHANGE !== 1'b0) begin n_bad++; $display("FAIL reset_mode got %0d/%b want 0/0", MODE, MODE_CHANGE); end
    RST_N = 1'b1;
    repeat (3) tick();
    n_cmp++; if (HELD !== 3'b000) begin n_bad++; $display("FAIL post_reset_held got %b want 000", HELD); end
  endtask

  task automatic test_bounce();
    int bounce_press = 0, press_cnt = 0, press_at = -1, short_cnt = 0, long_cnt = 0;
    BTN_N[0] = 1'b0;
    repeat (3) begin tick(); if (PRESS[0]) bounce_press++; end
    BTN_N[0] = 1'b1;
    repeat (2) begin tick(); if (PRESS[0]) bounce_press++; end
    BTN_N[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (PRESS[0]) begin press_cnt++; press_at = k; end
    end
    n_cmp++; if (bounce_press != 0) begin n_bad++; $display("FAIL bounce_press got %0d want 0", bounce_press); end
    n_cmp++; if (press_cnt != 1) begin n_bad++; $display("FAIL bounce_press_count got %0d want 1", press_cnt); end
    n_cmp++; if (press_at != 6) begin n_bad++; $display("FAIL bounce_press_edge got %0d want 6", press_at); end
    n_cmp++; if (HELD[0] !== 1'b1) begin n_bad++; $display("FAIL bounce_held got %b want 1", HELD[0]); end
    BTN_N[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (SHORT[0]) short_cnt++;
      if (LONG[0]) long_cnt++;
    end
    n_cmp++; if (short_cnt != 1 || long_cnt != 0) begin n_bad++; $display("FAIL bounce_release short/long got %0d/%0d want 1/0", short_cnt, long_cnt); end
    n_cmp++; if (HELD[0] !== 1'b0 || MODE !== 3'd0) begin n_bad++; $display("FAIL bounce_idle held/mode got %b/%0d want 0/0", HELD[0], MODE); end
  endtask

  task automatic test_short_press();
    for (int it = 0; it < 5; it++) begin
      int press_at = -1, short_at = -1, mc_at = -1, mc_cnt = 0;
      BTN_N[2] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        if (k == 9) BTN_N[2] = 1'b1;
        tick();
        if (PRESS[2]) press_at = k;
        if (SHORT[2]) short_at = k;
        if (MODE_CHANGE) begin mc_cnt++; mc_at = k; end
      end
      if (it == 0) begin
        n_cmp++; if (press_at != 6) begin n_bad++; $display("FAIL short_press_edge got %0d want 6", press_at); end
        n_cmp++; if (short_at != 14) begin n_bad++; $display("FAIL short_short_edge got %0d want 14", short_at); end
        n_cmp++; if (mc_at != 15) begin n_bad++; $display("FAIL short_mc_edge got %0d want 15", mc_at); end
      end
      n_cmp++; if (MODE !== 3'((it + 1) % 5)) begin n_bad++; $display("FAIL short_mode[%0d] got %0d want %0d", it, MODE, (it + 1) % 5); end
      n_cmp++; if (mc_cnt != 1) begin n_bad++; $display("FAIL short_mc_count[%0d] got %0d want 1", it, mc_cnt); end
    end
  endtask

  task automatic test_long_repeat();
    int long_at = -1, long_cnt = 0, rep_first = -1, rep_last = -1, rep_cnt = 0, short_cnt = 0;
    BTN_N[1] = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 37) BTN_N[1] = 1'b1;
      tick();
      if (LONG[1]) begin long_cnt++; long_at = k; end
      if (REPEAT[1]) begin rep_cnt++; rep_last = k; if (rep_first < 0) rep_first = k; end
      if (SHORT[1]) short_cnt++;
    end
    n_cmp++; if (long_at != 16 || long_cnt != 1) begin n_bad++; $display("FAIL long_edge got %0d x%0d want 16 x1", long_at, long_cnt); end
    n_cmp++; if (rep_first != 19) begin n_bad++; $display("FAIL repeat_first got %0d want 19", rep_first); end
    n_cmp++; if (rep_cnt != 8 || rep_last != 40) begin n_bad++; $display("FAIL repeat_count got %0d last %0d want 8 last 40", rep_cnt, rep_last); end
    n_cmp++; if (short_cnt != 0) begin n_bad++; $display("FAIL long_no_short got %0d want 0", short_cnt); end
    n_cmp++; if (MODE !== 3'd0 || HELD[1] !== 1'b0) begin n_bad++; $display("FAIL long_other_btn mode/held got %0d/%b want 0/0", MODE, HELD[1]); end
  endtask

  task automatic test_release_wins();
    int long_at = -1, rep_cnt = 0, short_cnt = 0, fall_at = -1;
    logic prev = 1'b0;
    BTN_N[1] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 17) BTN_N[1] = 1'b1;
      tick();
      if (LONG[1]) long_at = k;
      if (REPEAT[1]) rep_cnt++;
      if (SHORT[1]) short_cnt++;
      if (prev && !HELD[1]) fall_at = k;
      prev = HELD[1];
    end
    n_cmp++; if (fall_at != 22) begin n_bad++; $display("FAIL rw_fall_edge got %0d want 22", fall_at); end
    n_cmp++; if (long_at != 16 || rep_cnt != 1) begin n_bad++; $display("FAIL rw_events long %0d rep %0d want 16 rep 1", long_at, rep_cnt); end
    n_cmp++; if (short_cnt != 0) begin n_bad++; $display("FAIL rw_no_short got %0d want 0", short_cnt); end
  endtask

  task automatic test_mode_decrement();
    int mc_cnt = 0, short_cnt = 0;
    logic [2:0] seq [3];
    seq[0] = 3'd7; seq[1] = 3'd7; seq[2] = 3'd7;
    BTN_N[2] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 18) BTN_N[2] = 1'b1;
      tick();
      if (MODE_CHANGE) begin
        if (mc_cnt < 3) seq[mc_cnt] = MODE;
        mc_cnt++;
      end
      if (SHORT[2]) short_cnt++;
    end
    n_cmp++; if (mc_cnt != 3) begin n_bad++; $display("FAIL dec_mc_count got %0d want 3", mc_cnt); end
    n_cmp++; if (seq[0] !== 3'd4 || seq[1] !== 3'd3 || seq[2] !== 3'd2) begin n_bad++; $display("FAIL dec_sequence got %0d,%0d,%0d want 4,3,2", seq[0], seq[1], seq[2]); end
    n_cmp++; if (short_cnt != 0 || MODE !== 3'd2) begin n_bad++; $display("FAIL dec_final short %0d mode %0d want 0 mode 2", short_cnt, MODE); end
  endtask

  task automatic test_lock_load();
    int mc_cnt = 0, short_cnt = 0;
    MODE_LOCK = 1'b1;
    BTN_N[2] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 9) BTN_N[2] = 1'b1;
      tick();
      if (MODE_CHANGE) mc_cnt++;
      if (SHORT[2]) short_cnt++;
    end
    MODE_LOCK = 1'b0;
    n_cmp++; if (short_cnt != 1) begin n_bad++; $display("FAIL lock_short_event got %0d want 1", short_cnt); end
    n_cmp++; if (mc_cnt != 0 || MODE !== 3'd2) begin n_bad++; $display("FAIL lock_mode mc %0d mode %0d want 0 mode 2", mc_cnt, MODE); end
    MODE_LOAD = 1'b1; MODE_LOAD_VAL = 3'd3; tick();
    n_cmp++; if (MODE !== 3'd3 || MODE_CHANGE !== 1'b1) begin n_bad++; $display("FAIL load3 got %0d/%b want 3/1", MODE, MODE_CHANGE); end
    MODE_LOAD = 1'b0; tick();
    n_cmp++; if (MODE_CHANGE !== 1'b0) begin n_bad++; $display("FAIL load_strobe_clear got %b want 0", MODE_CHANGE); end
    MODE_LOAD = 1'b1; MODE_LOAD_VAL = 3'd6; tick();
    n_cmp++; if (MODE !== 3'd3 || MODE_CHANGE !== 1'b0) begin n_bad++; $display("FAIL load6_ignored got %0d/%b want 3/0", MODE, MODE_CHANGE); end
    MODE_LOAD_VAL = 3'd5; tick();
    n_cmp++; if (MODE !== 3'd3 || MODE_CHANGE !== 1'b0) begin n_bad++; $display("FAIL load5_ignored got %0d/%b want 3/0", MODE, MODE_CHANGE); end
    MODE_LOAD_VAL = 3'd3; tick();
    n_cmp++; if (MODE !== 3'd3 || MODE_CHANGE !== 1'b0) begin n_bad++; $display("FAIL load_same got %0d/%b want 3/0", MODE, MODE_CHANGE); end
    MODE_LOAD_VAL = 3'd4; tick();
    n_cmp++; if (MODE !== 3'd4 || MODE_CHANGE !== 1'b1) begin n_bad++; $display("FAIL load4 got %0d/%b want 4/1", MODE, MODE_CHANGE); end
    MODE_LOAD = 1'b0; MODE_LOAD_VAL = 3'd0; tick();
  endtask

  task automatic test_async_reset();
    int press_at = -1, mc_cnt = 0;
    BTN_N[2] = 1'b0;
    repeat (20) tick();
    n_cmp++; if (MODE !== 3'd2 || HELD[2] !== 1'b1) begin n_bad++; $display("FAIL pre_reset mode/held got %0d/%b want 2/1", MODE, HELD[2]); end
    #2 RST_N = 1'b0;
    #1;
    n_cmp++; if (HELD !== 3'b000 || {PRESS, SHORT, LONG, REPEAT} !== 12'h000) begin n_bad++; $display("FAIL async_reset_events held %b ev %h want 0/0", HELD, {PRESS, SHORT, LONG, REPEAT}); end
    n_cmp++; if (MODE !== 3'd0 || MODE_CHANGE !== 1'b0) begin n_bad++; $display("FAIL async_reset_mode got %0d/%b want 0/0", MODE, MODE_CHANGE); end
    repeat (2) tick();
    RST_N = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (PRESS[2]) press_at = k;
      if (MODE_CHANGE) mc_cnt++;
    end
    n_cmp++; if (press_at != 6) begin n_bad++; $display("FAIL reset_repress_edge got %0d want 6", press_at); end
    n_cmp++; if (MODE !== 3'd0 || mc_cnt != 0) begin n_bad++; $display("FAIL reset_repress_mode got %0d mc %0d want 0 mc 0", MODE, mc_cnt); end
    BTN_N[2] = 1'b1;
    repeat (12) tick();
    n_cmp++; if (MODE !== 3'd1) begin n_bad++; $display("FAIL post_reset_step got %0d want 1", MODE); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bounce();
    test_short_press();
    test_long_repeat();
    test_release_wins();
    test_mode_decrement();
    test_lock_load();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
